// File: rtl/mem_ctrl_arbiter.sv
// Byte-serial RAM/IO responder: MEM has fixed priority over IF, registered bus
// outputs, read data returned LAT cycles after acceptance on the issuing client port.
module mem_ctrl_arbiter #(
   parameter logic [31:0] IO_BASE = 32'h00030000,
   parameter int unsigned LAT     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_r_w,
   input  logic [31:0] mem_req_addr,
   input  logic [7:0]  mem_req_data,
   output logic        mem_grant_o,
   output logic [7:0]  mem_data_o,
   output logic        mem_data_valid_o,
   input  logic        if_req,
   input  logic [31:0] if_req_addr,
   output logic        if_grant_o,
   output logic [7:0]  if_data_o,
   output logic        if_data_valid_o,
   input  logic [7:0]  ram_din,
   input  logic        io_buffer_full,
   output logic [31:0] ram_a,
   output logic [7:0]  ram_dout,
   output logic        ram_wr
);

   logic            mem_io_block;
   logic            rd_issue;
   logic            rd_client;
   logic [31:0]     ram_a_q, ram_a_d;
   logic [7:0]      ram_dout_q, ram_dout_d;
   logic            ram_wr_q, ram_wr_d;
   logic [7:0]      mem_data_q, mem_data_d;
   logic [7:0]      if_data_q, if_data_d;
   // Tag shift register: bit 0 is stage 1; client 1 = MEM, 0 = IF.
   logic [LAT-1:0]  tag_v_q, tag_v_d;
   logic [LAT-1:0]  tag_c_q, tag_c_d;

   // IF is refused whenever MEM requests (even when blocked) so fetches cannot
   // overtake a held-off store.
   assign mem_io_block = mem_req & mem_r_w & (mem_req_addr >= IO_BASE) & io_buffer_full;
   assign mem_grant_o  = mem_req & ~mem_io_block & ~rst;
   assign if_grant_o   = if_req & ~mem_req & ~rst;

   assign rd_issue  = (mem_grant_o & ~mem_r_w) | if_grant_o;
   assign rd_client = mem_grant_o;

   always_comb begin
      ram_a_d    = ram_a_q;
      ram_dout_d = ram_dout_q;
      ram_wr_d   = 1'b0;
      mem_data_d = mem_data_q;
      if_data_d  = if_data_q;
      tag_v_d    = {tag_v_q[LAT-2:0], rd_issue};
      tag_c_d    = {tag_c_q[LAT-2:0], rd_client};
      if (mem_grant_o) begin
         ram_a_d  = mem_req_addr;
         ram_wr_d = mem_r_w;
         if (mem_r_w) ram_dout_d = mem_req_data;
      end else if (if_grant_o) begin
         ram_a_d = if_req_addr;
      end
      if (tag_v_q[LAT-2]) begin
         if (tag_c_q[LAT-2]) mem_data_d = ram_din;
         else                if_data_d  = ram_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_a_q    <= '0;
         ram_dout_q <= '0;
         ram_wr_q   <= 1'b0;
         mem_data_q <= '0;
         if_data_q  <= '0;
         tag_v_q    <= '0;
         tag_c_q    <= '0;
      end else begin
         ram_a_q    <= ram_a_d;
         ram_dout_q <= ram_dout_d;
         ram_wr_q   <= ram_wr_d;
         mem_data_q <= mem_data_d;
         if_data_q  <= if_data_d;
         tag_v_q    <= tag_v_d;
         tag_c_q    <= tag_c_d;
      end
   end

   assign ram_a            = ram_a_q;
   assign ram_dout         = ram_dout_q;
   assign ram_wr           = ram_wr_q;
   assign mem_data_o       = mem_data_q;
   assign if_data_o        = if_data_q;
   assign mem_data_valid_o = tag_v_q[LAT-1] & tag_c_q[LAT-1];
   assign if_data_valid_o  = tag_v_q[LAT-1] & ~tag_c_q[LAT-1];

endmodule
